// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: fetch FSM states, queue entry layout,
// and the JAL target helper used when JAL_REDIRECT_EN is defined.
package inst_fetcher_pkg;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // J-type immediate is sign-extended and already has its implicit zero LSB
  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] d);
    return pc + {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// In-order instruction queue: circular buffer with wrapping head/tail pointers,
// single-cycle flush, and a combinational head read.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 96
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed while count says they are live
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[tail] <= push_data;
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding memory request at a time, results queued in order
// with their PC and predicted next PC. Optional macro JAL_REDIRECT_EN follows JAL targets.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 8,
  parameter int          QUEUE_AW    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ifetch_req,
  output logic [31:0] ifetch_addr,
  input  logic        ifetch_done,
  input  logic [31:0] ifetch_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);

  fetch_state_t      state;
  logic [31:0]       pc;
  logic [31:0]       pred_pc;
  logic              q_push;
  logic              q_pop;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  logic [QUEUE_AW:0] q_count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

`ifdef JAL_REDIRECT_EN
  always_comb begin
    pred_pc = pc + 32'd4;
    if (ifetch_data[6:0] == OPC_JAL) pred_pc = jal_target(pc, ifetch_data);
  end
`else
  assign pred_pc = pc + 32'd4;
`endif

  // While waiting, pc still equals the outstanding request address
  assign push_entry = '{word: ifetch_data, pc: pc, pred_pc: pred_pc};

  assign q_flush = rdy_in & flush_in;
  assign q_push  = rdy_in & ~flush_in & (state == FS_WAIT) & ifetch_done;
  assign q_pop   = rdy_in & ~flush_in & ~q_empty & inst_ready;

  inst_queue #(
    .DEPTH (QUEUE_DEPTH),
    .AW    (QUEUE_AW),
    .W     (ENTRY_W)
  ) u_queue (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (q_flush),
    .push_data (push_entry),
    .head_data (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign inst_valid   = (q_count != '0);
  assign inst         = head_entry.word;
  assign inst_pc      = head_entry.pc;
  assign inst_pred_pc = head_entry.pred_pc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= FS_IDLE;
      pc          <= RESET_PC;
      ifetch_req  <= 1'b0;
      ifetch_addr <= 32'h0;
    end else if (rdy_in) begin
      unique case (state)
        FS_IDLE: begin
          if (flush_in) begin
            pc <= flush_pc;
          end else if (!q_full) begin
            ifetch_req  <= 1'b1;
            ifetch_addr <= pc;
            state       <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (flush_in) begin
            pc <= flush_pc;
            if (ifetch_done) begin
              ifetch_req <= 1'b0;
              state      <= FS_IDLE;
            end else begin
              state <= FS_DISCARD;
            end
          end else if (ifetch_done) begin
            pc         <= pred_pc;
            ifetch_req <= 1'b0;
            state      <= FS_IDLE;
          end
        end
        FS_DISCARD: begin
          if (flush_in) pc <= flush_pc;
          if (ifetch_done) begin
            ifetch_req <= 1'b0;
            state      <= FS_IDLE;
          end
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule
